// File: rtl/data_memory.sv
// Multi-cycle RV32IM data memory: IDLE/BUSY/ACK handshake, byte/half/word lanes, sign/zero-extended loads.
// Optional DATA_MEM_MISALIGN_ERR_EN adds a MISALIGN flag and suppresses misaligned accesses.
module data_memory #(
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 4
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [3:0]  READ,
    input  logic [2:0]  WRITE,
    input  logic [31:0] ADDRESS,
    input  logic [31:0] WRITEDATA,
    output logic [31:0] READDATA,
    output logic        BUSYWAIT
`ifdef DATA_MEM_MISALIGN_ERR_EN
    ,
    output logic        MISALIGN
`endif
);

    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

    state_t                  state_reg;
    logic [3:0]              count_reg;
    logic                    load_reg;
    logic                    store_reg;
    logic [2:0]              lfunct_reg;
    logic [1:0]              sfunct_reg;
    logic [ADDR_WIDTH+1:0]   addr_reg;
    logic [31:0]             wdata_reg;
    logic [31:0]             rd_word_reg;

    logic [31:0] mem [2**ADDR_WIDTH];

    logic                    req;
    logic                    do_access;
    logic [ADDR_WIDTH-1:0]   word_idx;
    logic [1:0]              lane;
    logic [7:0]              lane_byte [4];
    logic [7:0]              sel_byte;
    logic [15:0]             sel_half;
    logic                    misaligned;
    logic                    blocked;
    logic [3:0]              byte_en;
    logic [31:0]             store_lanes;
    logic [31:0]             load_val;
    logic                    unused_addr;

    assign req         = READ[3] | WRITE[2];
    assign do_access   = (state_reg == BUSY) && (count_reg == 4'd0);
    assign word_idx    = addr_reg[ADDR_WIDTH+1:2];
    assign lane        = addr_reg[1:0];
    assign unused_addr = ^ADDRESS[31:ADDR_WIDTH+2];

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane_byte[gi] = rd_word_reg[gi*8 +: 8];
    end

    assign sel_byte = lane_byte[lane];
    assign sel_half = lane[1] ? rd_word_reg[31:16] : rd_word_reg[15:0];

    // A store takes precedence over a simultaneous load, so it decides the alignment check.
    always_comb begin
        misaligned = 1'b0;
        if (store_reg) begin
            misaligned = ((sfunct_reg == 2'b01) && lane[0]) ||
                         ((sfunct_reg == 2'b10) && (lane != 2'b00));
        end else if (load_reg) begin
            misaligned = (((lfunct_reg == 3'b001) || (lfunct_reg == 3'b101)) && lane[0]) ||
                         ((lfunct_reg == 3'b010) && (lane != 2'b00));
        end
    end

`ifdef DATA_MEM_MISALIGN_ERR_EN
    assign blocked = misaligned;
`else
    assign blocked = 1'b0;
`endif

    always_comb begin
        byte_en     = 4'b0000;
        store_lanes = wdata_reg;
        if (store_reg && !blocked) begin
            case (sfunct_reg)
                2'b00: begin
                    byte_en     = 4'b0001 << lane;
                    store_lanes = {4{wdata_reg[7:0]}};
                end
                2'b01: begin
                    byte_en     = lane[1] ? 4'b1100 : 4'b0011;
                    store_lanes = {2{wdata_reg[15:0]}};
                end
                2'b10: byte_en = 4'b1111;
                default: byte_en = 4'b0000;
            endcase
        end
    end

    always_comb begin
        load_val = 32'd0;
        if (!blocked) begin
            case (lfunct_reg)
                3'b000:  load_val = {{24{sel_byte[7]}}, sel_byte};
                3'b001:  load_val = {{16{sel_half[15]}}, sel_half};
                3'b010:  load_val = rd_word_reg;
                3'b100:  load_val = {24'd0, sel_byte};
                3'b101:  load_val = {16'd0, sel_half};
                default: load_val = 32'd0;
            endcase
        end
    end

    // Storage has no reset; the word is read when the request is accepted so it is ready in BUSY.
    always_ff @(posedge CLK) begin
        if (state_reg == IDLE && req) begin
            rd_word_reg <= mem[ADDRESS[ADDR_WIDTH+1:2]];
        end
        if (do_access) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[word_idx][i*8 +: 8] <= store_lanes[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg  <= IDLE;
            count_reg  <= 4'd0;
            load_reg   <= 1'b0;
            store_reg  <= 1'b0;
            lfunct_reg <= 3'd0;
            sfunct_reg <= 2'd0;
            addr_reg   <= '0;
            wdata_reg  <= 32'd0;
            READDATA   <= 32'd0;
`ifdef DATA_MEM_MISALIGN_ERR_EN
            MISALIGN   <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req) begin
                        load_reg   <= READ[3];
                        store_reg  <= WRITE[2];
                        lfunct_reg <= READ[2:0];
                        sfunct_reg <= WRITE[1:0];
                        addr_reg   <= ADDRESS[ADDR_WIDTH+1:0];
                        wdata_reg  <= WRITEDATA;
                        count_reg  <= 4'(LATENCY - 1);
                        state_reg  <= BUSY;
                    end
                end
                BUSY: begin
                    if (count_reg == 4'd0) begin
                        if (load_reg && !store_reg) begin
                            READDATA <= load_val;
                        end
`ifdef DATA_MEM_MISALIGN_ERR_EN
                        MISALIGN <= misaligned;
`endif
                        state_reg <= ACK;
                    end else begin
                        count_reg <= count_reg - 4'd1;
                    end
                end
                ACK: begin
`ifdef DATA_MEM_MISALIGN_ERR_EN
                    MISALIGN <= 1'b0;
`endif
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_comb begin
        case (state_reg)
            IDLE:    BUSYWAIT = req;
            BUSY:    BUSYWAIT = 1'b1;
            default: BUSYWAIT = 1'b0;
        endcase
    end

endmodule
